if_stage: RTL

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the program counter and selects the next PC from sequential, ID-stage jump, or EX-stage branch redirects.
- Drives the instruction memory address and presents the PC/instruction pair to IF/ID, together with the flush strobes for IF/ID and ID/EX.
- Buffers a redirect that arrives during a hold, and implements a halt state entered on syscall-halt.

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage_pc_next_sel.sv | 39 +++
 rtl/if_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSN_BYTES       = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Redirect targets are always forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// rtl/if_stage_pc_next_sel.sv - next-PC priority mux and redirect alignment check
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        pending_valid,
    input  logic [31:0] pending_target,
    output logic [31:0] next_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_target,
    output logic        misalign
);

    // Branch (older instruction) beats jump; a buffered redirect sits between them.
    always_comb begin
        redirect_valid  = br_taken | jmp;
        redirect_target = br_taken ? align_word(br_target) : align_word(jmp_target);
        misalign        = 1'b0;
        if (br_taken) begin
            misalign = |br_target[1:0];
        end else if (jmp) begin
            misalign = |jmp_target[1:0];
        end

        next_pc = pc + INSN_BYTES;
        if (br_taken) begin
            next_pc = align_word(br_target);
        end else if (pending_valid) begin
            next_pc = pending_target;
        end else if (jmp) begin
            next_pc = align_word(jmp_target);
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, pending redirect, halt FSM, fetch counter
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    input  logic             halt,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_out,
    output logic [31:0]      ir_out,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      pc_q;
    logic             pend_valid_q;
    logic             pend_is_br_q;
    logic [31:0]      pend_target_q;
    logic             misalign_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      next_pc;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             misalign;
    logic             run;
    logic             advance;
    logic             capture;

    pc_next_sel u_pc_next_sel (
        .pc              (pc_q),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .jmp             (jmp),
        .jmp_target      (jmp_target),
        .pending_valid   (pend_valid_q),
        .pending_target  (pend_target_q),
        .next_pc         (next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign        (misalign)
    );

    assign run = (state_q == RUN);

    // A redirect seen during a hold is buffered; a jump may not displace a buffered branch.
    assign capture = run & hold & redirect_valid & (br_taken | ~(pend_valid_q & pend_is_br_q));

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and PC-advance decision; halt only lands when nothing redirects this edge.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            RUN: begin
                if (!hold) begin
                    if (halt && !br_taken && !pend_valid_q) begin
                        state_d = HALTED;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // PC and fetch counter move together on every unheld RUN edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else if (advance) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // One-entry pending redirect: filled during hold, drained on the first unheld edge.
    always_ff @(posedge clr or posedge clk) begin
        if (clr) begin
            pend_valid_q  <= 1'b0;
            pend_is_br_q  <= 1'b0;
            pend_target_q <= '0;
        end else if (advance) begin
            pend_valid_q  <= 1'b0;
            pend_is_br_q  <= 1'b0;
        end else if (capture) begin
            pend_valid_q  <= 1'b1;
            pend_is_br_q  <= br_taken;
            pend_target_q <= redirect_target;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            misalign_q <= 1'b0;
        end else if (run && misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign ir_out       = imem_rdata;
    assign flush_if_id  = run & redirect_valid & ~clr;
    assign flush_id_ex  = run & br_taken & ~clr;
    assign halted       = ~run;
    assign misalign_err = misalign_q;
    assign fetch_cnt    = cnt_q;

endmodule
